tg_bus_arbiter: RTL
===================

# tg_bus_arbiter

Round-robin enable generator for a shared line driven by N transmission gates (TG instances). It sits directly upstream of the TG array: each `en[i]` drives the enable of TG `i`. Only one gate may conduct at a time. A guaranteed all-off turnaround gap separates successive owners, so two drivers never fight the line. A hold limit stops any single requester from monopolising the bus.

## Interface
Parameters:
- `N`, 4: number of requesters / TG enables; legal range 2..16
- `HOLD_MAX`, 8: maximum consecutive cycles one grant may stay asserted; legal range 1..255
- `GAP`, 1: turnaround cycles with all enables low between owners; legal range 1..15

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `req`  in  N  level requests; `req[i]` is held high while requester `i` wants the line
- `en`  out  N  one-hot-or-zero registered TG enables
- `owner`  out  clog2(N)  index of the current owner; holds the last owner when `en` == 0
- `busy`  out  1  high when `en` != 0
- `preempt`  out  1  one-cycle pulse when a grant is removed by the hold limit

## Operation
- State machine with states IDLE, GRANT and TURN. Reset state is IDLE.
- Reset values: `en`=0, `owner`=0, `busy`=0, `preempt`=0. The rotation pointer resets so that index 0 has top priority.
- IDLE:
  - If `req` != 0, pick the first set bit searching upward from `ptr`, wrapping modulo N.
  - Register `en` = one-hot of the winner, load `owner` and `ptr` = winner+1 (mod N), clear the hold counter, and go to GRANT.
  - If `req` == 0, stay in IDLE.
- GRANT:
  - The hold counter increments every cycle while `en` is asserted.
  - Release when `req[owner]` is sampled low, or when the counter reaches `HOLD_MAX`.
  - On release: `en` goes to 0 next cycle and the state moves to TURN with `gap_cnt` = GAP.
  - On a hold-limit release, `preempt` pulses high for that same single cycle. If both release conditions hold at once, treat it as a normal release with no `preempt`.
- TURN:
  - `en` stays 0 and `gap_cnt` decrements each cycle.
  - On the cycle `gap_cnt` reaches 1, arbitrate exactly as in IDLE. On a winner go to GRANT; otherwise go to IDLE.
- Requests from non-owners during GRANT are ignored until arbitration. Requests that drop before arbitration are forgotten; nothing is queued.
- A preempted owner that keeps `req` high competes normally in the next arbitration. Because `ptr` has already advanced past it, other pending requesters win first.

## Timing
- Grant latency from IDLE: `req` sampled high at edge k gives `en` high after edge k (visible in the cycle following edge k). That is one cycle of latency.
- Release latency: `req[owner]` low sampled at edge k gives `en` = 0 after edge k.
- Back-to-back owners: `en` is all-zero for exactly GAP cycles when another request is pending, and never fewer.
- Hold limit: `en[owner]` is high for at most HOLD_MAX consecutive cycles.
- `busy` and `owner` are registered together with `en`; there is no combinational path from `req` to any output.
- If reset is asserted mid-grant or mid-gap, all outputs are at their reset values after that edge. No partial enable is permitted.
- Invariant: `en` is never multi-hot in any cycle, including the cycles around reset.

## Structure
- Shared package `tg_pkg`:
  - state enum `tg_arb_state_t` with values IDLE, GRANT and TURN
  - function `rr_pick(req, ptr)` returning a valid flag and an index
- One natural sub-module, `rr_priority_pick`, a combinational rotating priority encoder of width N. It is instantiated once and used by both IDLE and TURN arbitration.
- The top level holds the FSM, the `ptr`, hold and gap counters, and the output registers.

## Test plan
- Single requester, N=4: `req`=0001 at cycle 2 and dropped at cycle 6. Required response: `en`=0001 for cycles 3–6, `en`=0 from cycle 7, `busy` tracking `en`, `preempt` never asserted.
- Simultaneous requests from reset: `req`=1111 held, each owner dropping after 2 cycles. Required response: grant order 0,1,2,3,0; exactly GAP=1 zero cycle between owners; `en` always one-hot or zero.
- Hold limit, HOLD_MAX=3: `req`=0100 held forever. Required response: `en`=0100 for 3 cycles, `preempt` pulse on the drop cycle, 1 gap cycle, then re-grant of 0100. The pattern repeats.
- Fairness after preemption: `req`=0011 held with HOLD_MAX=3. Required response: owner sequence 0,1,0,1, each owner holding 3 cycles.
- Reset mid-grant: `rst_n` low for one edge while `en`=0010. Required response: next cycle `en`=0, `owner`=0, `busy`=0; with `req`=0010 still high, re-grant follows one cycle after `rst_n` returns high.
- Wrap-around with GAP=3: owner 3 releases while `req`=0001. Required response: `en`=0 for exactly 3 cycles, then `en`=0001.

Source files
------------

// File: rtl/tg_bus_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the TG bus arbiter.
package tg_pkg;

    // Widest supported requester vector and the index width that covers it.
    localparam int MAX_N  = 16;
    localparam int IDX_W  = 4;
    // Hold counter covers HOLD_MAX up to 255, gap counter covers GAP up to 15.
    localparam int HOLD_W = 8;
    localparam int GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } tg_arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or above ptr, wrapping at n. Bits at or above n
    // are never examined, so callers may leave them at any value.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [IDX_W-1:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       pos;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if (k < n && !r.valid && req[pos[IDX_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = pos[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tg_bus_arbiter_pick.sv
// Combinational rotating priority encoder: lowest set request at or above ptr,
// wrapping modulo N. Shared by the IDLE and TURN arbitration paths.
import tg_pkg::*;

module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_N-1:0] req_ext;
    rr_pick_t         pick;

    // Zero-extend the request vector and run the wrap-around search.
    always_comb begin
        req_ext = MAX_N'(req);
        pick    = rr_pick(req_ext, ptr, N);
    end

    assign valid = pick.valid;
    assign idx   = pick.idx;

endmodule

// File: rtl/tg_bus_arbiter.sv
// Round-robin enable generator for a line shared by N transmission gates.
// At most one enable is high; owners are separated by GAP all-off cycles and
// a single grant is cut off after HOLD_MAX cycles.
import tg_pkg::*;

module tg_bus_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int GAP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam int W = $clog2(N);

    tg_arb_state_t     state_q, state_d;
    logic [N-1:0]      en_q, en_d;
    logic [W-1:0]      owner_q, owner_d;
    logic [W-1:0]      ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  ptr_ext;
    logic [W-1:0]      win;
    logic [W-1:0]      win_next;
    logic [N-1:0]      win_onehot;
    logic              unused_pick;

    logic [HOLD_W-1:0] hold_inc;
    logic              owner_drop;
    logic              hold_hit;
    logic              arb_now;

    assign ptr_ext = IDX_W'(ptr_q);

    rr_priority_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_ext),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // The encoder index is always below N, so only the low W bits carry data.
    assign win         = pick_idx[W-1:0];
    assign unused_pick = ^pick_idx;

    // Winner as a one-hot enable and the pointer value that follows it.
    always_comb begin
        win_onehot = {{(N-1){1'b0}}, 1'b1} << win;
        win_next   = (win == W'(N - 1)) ? '0 : win + 1'b1;
    end

    // Release and arbitration conditions derived from registered state.
    always_comb begin
        hold_inc   = hold_q + 1'b1;
        owner_drop = ~req[owner_q];
        hold_hit   = (hold_inc == HOLD_W'(HOLD_MAX));
        arb_now    = (state_q == IDLE) ||
                     ((state_q == TURN) && (gap_q == GAP_W'(1)));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant on a winner, turn around after every release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_drop || hold_hit) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                if (gap_q == GAP_W'(1)) begin
                    state_d = pick_valid ? GRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath: enable, owner, pointer, hold and gap counters.
    // en_d defaults to zero so every path that leaves GRANT drops the enable.
    always_comb begin
        en_d      = '0;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE, TURN: begin
                if (arb_now && pick_valid) begin
                    en_d    = win_onehot;
                    owner_d = win;
                    ptr_d   = win_next;
                    hold_d  = '0;
                end else if (state_q == TURN) begin
                    gap_d = gap_q - 1'b1;
                end
            end
            GRANT: begin
                if (owner_drop || hold_hit) begin
                    gap_d     = GAP_W'(GAP);
                    // A voluntary release wins over a coincident hold-limit hit.
                    preempt_d = hold_hit && !owner_drop;
                end else begin
                    en_d   = en_q;
                    hold_d = hold_inc;
                end
            end
            default: begin
                en_d = '0;
            end
        endcase
        busy_d = |en_d;
    end

    // Output and datapath registers; reset leaves every enable low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q      <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign en      = en_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
